// File: rtl/round_controller.sv
// Round sequencer for a card hand: deals cards on entry to each round, steps
// rounds on advance, and resolves the final tally round as a new hand or a cashout.
module round_controller #(
  parameter int NUM_ROUNDS = 5,
  parameter int DEAL_FIRST = 4,
  parameter int DEAL_REST  = 1,
  parameter int HAND_W     = 8,
  localparam int RW = ($clog2(NUM_ROUNDS) < 1) ? 1 : $clog2(NUM_ROUNDS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              advance,
  input  logic              cashout,
  input  logic              deal_ack,
  input  logic [3:0]        deal_data,
  output logic              deal_req,
  output logic [3:0]        card_out,
  output logic              card_valid,
  output logic [RW-1:0]     round,
  output logic              cashed_out,
  output logic              hand_done,
  output logic [HAND_W-1:0] hand_cnt
);

  typedef enum logic [1:0] {
    S_INIT    = 2'd0,
    S_DEAL    = 2'd1,
    S_WAIT    = 2'd2,
    S_CASHOUT = 2'd3
  } state_t;

  localparam logic [RW-1:0] LAST_ROUND   = RW'(NUM_ROUNDS - 1);
  localparam logic [3:0]    DEAL_FIRST_C = 4'(DEAL_FIRST);
  localparam logic [3:0]    DEAL_REST_C  = 4'(DEAL_REST);

  state_t              state, state_next;
  logic [3:0]          deal_cnt, deal_cnt_next;
  logic [RW-1:0]       round_next;
  logic [3:0]          card_next;
  logic                card_valid_next;
  logic                hand_done_next;
  logic [HAND_W-1:0]   hand_cnt_next;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    state_next      = state;
    deal_cnt_next   = deal_cnt;
    round_next      = round;
    card_next       = card_out;
    card_valid_next = 1'b0;
    hand_done_next  = 1'b0;
    hand_cnt_next   = hand_cnt;

    unique case (state)
      S_INIT: begin
        state_next    = S_DEAL;
        round_next    = '0;
        deal_cnt_next = DEAL_FIRST_C;
      end

      S_DEAL: begin
        // advance is deliberately not looked at here: it is dropped, not queued
        if (deal_ack) begin
          card_next       = deal_data;
          card_valid_next = 1'b1;
          deal_cnt_next   = deal_cnt - 4'd1;
          if (deal_cnt == 4'd1) state_next = S_WAIT;
        end
      end

      S_WAIT: begin
        if (round == LAST_ROUND) begin
          if (cashout) begin
            state_next = S_CASHOUT;
          end else if (advance) begin
            round_next     = '0;
            hand_done_next = 1'b1;
            hand_cnt_next  = hand_cnt + 1'b1;
            deal_cnt_next  = DEAL_FIRST_C;
            state_next     = S_DEAL;
          end
        end else if (advance) begin
          round_next = round + 1'b1;
          // entering the tally round never deals
          if (round_next != LAST_ROUND && DEAL_REST > 0) begin
            deal_cnt_next = DEAL_REST_C;
            state_next    = S_DEAL;
          end
        end
      end

      S_CASHOUT: begin
        if (!cashout) begin
          round_next     = '0;
          hand_done_next = 1'b1;
          hand_cnt_next  = hand_cnt + 1'b1;
          state_next     = S_INIT;
        end
      end

      default: state_next = S_INIT;
    endcase
  end

  // Outputs are flopped from next-state values so none of them sees an input
  // combinationally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_INIT;
      deal_cnt   <= '0;
      round      <= '0;
      card_out   <= '0;
      card_valid <= 1'b0;
      hand_done  <= 1'b0;
      hand_cnt   <= '0;
      deal_req   <= 1'b0;
      cashed_out <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state      <= state_next;
      deal_cnt   <= deal_cnt_next;
      round      <= round_next;
      card_out   <= card_next;
      card_valid <= card_valid_next;
      hand_done  <= hand_done_next;
      hand_cnt   <= hand_cnt_next;
      deal_req   <= (state_next == S_DEAL);
      cashed_out <= (state_next == S_CASHOUT);
    end
  end

endmodule

// File: tb/tb_round_controller.sv
// Scoreboard bench for round_controller: dut0 uses default parameters,
// dut1 uses NUM_ROUNDS=3 with DEAL_REST=0.
module tb_round_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] rst, advance, cashout, deal_ack;
  logic [3:0] deal_data [2];
  logic [1:0] deal_req, card_valid, cashed_out, hand_done;
  logic [3:0] card_out [2];
  logic [7:0] hand_cnt [2];
  logic [2:0] round0;
  logic [1:0] round1;

  round_controller dut0 (
    .clk(clk), .rst(rst[0]), .advance(advance[0]), .cashout(cashout[0]),
    .deal_ack(deal_ack[0]), .deal_data(deal_data[0]), .deal_req(deal_req[0]),
    .card_out(card_out[0]), .card_valid(card_valid[0]), .round(round0),
    .cashed_out(cashed_out[0]), .hand_done(hand_done[0]), .hand_cnt(hand_cnt[0])
  );

  round_controller #(.NUM_ROUNDS(3), .DEAL_REST(0)) dut1 (
    .clk(clk), .rst(rst[1]), .advance(advance[1]), .cashout(cashout[1]),
    .deal_ack(deal_ack[1]), .deal_data(deal_data[1]), .deal_req(deal_req[1]),
    .card_out(card_out[1]), .card_valid(card_valid[1]), .round(round1),
    .cashed_out(cashed_out[1]), .hand_done(hand_done[1]), .hand_cnt(hand_cnt[1])
  );

  typedef struct { int d; int val; } ev_t;
  typedef struct { int d; int rnd; int req; int cashed; int hcnt; int card; } probe_t;

  ev_t    card_q[$];
  ev_t    hand_q[$];
  probe_t probe_q[$];

  int n_checks = 0;
  int n_errors = 0;
  int cycles   = 0;
  bit done     = 1'b0;
  int last_card [2];

  task automatic check(input int d, input string name,
                       input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL dut%0d %s: got %0d, expected %0d", d, name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_probe(input int d, input int rnd, input int req,
                              input int cashed, input int hcnt);
    probe_q.push_back('{d, rnd, req, cashed, hcnt, last_card[d]});
  endtask

  task automatic push_card(input int d, input int v);
    card_q.push_back('{d, v});
  endtask

  task automatic adv(input int d);
    advance[d] = 1'b1;
    tick();
    advance[d] = 1'b0;
  endtask

  task automatic deal(input int d, input int n, input int first);
    for (int k = 0; k < 20 && !deal_req[d]; k++) tick();
    for (int i = 0; i < n; i++) begin
      deal_data[d] = 4'(first + i);
      push_card(d, (first + i) & 15);
      last_card[d] = (first + i) & 15;
      deal_ack[d] = 1'b1;
      tick();
    end
    deal_ack[d] = 1'b0;
  endtask

  // Monitor: compares every DUT event and every queued probe on the falling edge.
  initial begin : monitor
    ev_t    e;
    probe_t p;
    forever begin
      @(negedge clk);
      cycles++;
      for (int d = 0; d < 2; d++) begin
        if (card_valid[d]) begin
          check(d, "card_event_expected",
                32'(card_q.size() > 0 && card_q[0].d == d), 1);
          if (card_q.size() > 0 && card_q[0].d == d) begin
            e = card_q.pop_front();
            check(d, "card_out", 32'(card_out[d]), e.val);
          end
        end
        if (hand_done[d]) begin
          check(d, "hand_done_expected",
                32'(hand_q.size() > 0 && hand_q[0].d == d), 1);
          if (hand_q.size() > 0 && hand_q[0].d == d) begin
            e = hand_q.pop_front();
            check(d, "hand_cnt_at_done", 32'(hand_cnt[d]), e.val);
          end
        end
      end
      while (probe_q.size() > 0) begin
        p = probe_q.pop_front();
        check(p.d, "round", p.d != 0 ? 32'(round1) : 32'(round0), p.rnd);
        check(p.d, "deal_req", 32'(deal_req[p.d]), p.req);
        check(p.d, "cashed_out", 32'(cashed_out[p.d]), p.cashed);
        check(p.d, "hand_cnt", 32'(hand_cnt[p.d]), p.hcnt);
        check(p.d, "card_out", 32'(card_out[p.d]), p.card);
      end
      if (done || cycles > 3000) begin
        check(0, "stimulus_finished_in_time", 32'(done), 1);
        check(0, "card_events_outstanding", 32'(card_q.size()), 0);
        check(0, "hand_events_outstanding", 32'(hand_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
      end
    end
  end

  initial begin : stimulus
    rst = 2'b11; advance = '0; cashout = '0; deal_ack = '0;
    deal_data[0] = '0; deal_data[1] = '0;
    last_card[0] = 0; last_card[1] = 0;
    repeat (2) tick();
    expect_probe(0, 0, 0, 0, 0);
    expect_probe(1, 0, 0, 0, 0);
    tick();

    // Ack held from reset release: INIT ignores it, then four cards 3,7,9,2.
    deal_data[0] = 4'd3; deal_ack[0] = 1'b1; rst = 2'b00;
    expect_probe(0, 0, 0, 0, 0);
    tick();
    expect_probe(0, 0, 1, 0, 0);
    push_card(0, 3); push_card(0, 7); push_card(0, 9); push_card(0, 2);
    tick(); deal_data[0] = 4'd7;
    tick(); deal_data[0] = 4'd9;
    tick(); deal_data[0] = 4'd2;
    tick();
    last_card[0] = 2;
    expect_probe(0, 0, 0, 0, 0);
    deal_data[0] = 4'd15;
    repeat (2) tick();
    deal_ack[0] = 1'b0;
    expect_probe(0, 0, 0, 0, 0);

    // Rounds 1..3 deal one card each, round 4 (tally) deals nothing.
    for (int r = 1; r <= 3; r++) begin
      adv(0);
      deal(0, 1, 4 + r);
      expect_probe(0, r, 0, 0, 0);
    end
    adv(0);
    expect_probe(0, 4, 0, 0, 0);
    repeat (2) tick();
    expect_probe(0, 4, 0, 0, 0);

    // Cashout beats a simultaneous advance; advance ignored while cashed out.
    cashout[0] = 1'b1; advance[0] = 1'b1;
    tick();
    advance[0] = 1'b0;
    expect_probe(0, 4, 0, 1, 0);
    adv(0);
    expect_probe(0, 4, 0, 1, 0);
    hand_q.push_back('{0, 1});
    cashout[0] = 1'b0;
    tick();
    expect_probe(0, 0, 0, 0, 1);
    tick();
    expect_probe(0, 0, 1, 0, 1);

    // advance during a stalled deal is dropped and never replayed.
    adv(0);
    repeat (2) tick();
    expect_probe(0, 0, 1, 0, 1);
    deal(0, 4, 1);
    expect_probe(0, 0, 0, 0, 1);
    repeat (3) tick();
    expect_probe(0, 0, 0, 0, 1);

    // cashout outside the tally round has no effect; normal hand wrap.
    adv(0);
    deal(0, 1, 8);
    cashout[0] = 1'b1;
    tick();
    cashout[0] = 1'b0;
    expect_probe(0, 1, 0, 0, 1);
    adv(0); deal(0, 1, 9);
    adv(0); deal(0, 1, 10);
    adv(0);
    expect_probe(0, 4, 0, 0, 1);
    hand_q.push_back('{0, 2});
    adv(0);
    expect_probe(0, 0, 1, 0, 2);

    // Asynchronous reset after two of four acks, then a fresh four-card deal.
    deal(0, 2, 11);
    expect_probe(0, 0, 1, 0, 2);
    tick();
    #2;
    rst[0] = 1'b1;
    last_card[0] = 0;
    expect_probe(0, 0, 0, 0, 0);
    tick();
    rst[0] = 1'b0;
    expect_probe(0, 0, 0, 0, 0);
    tick();
    expect_probe(0, 0, 1, 0, 0);
    deal(0, 4, 2);
    expect_probe(0, 0, 0, 0, 0);

    // dut1: no deal on rest rounds, wrap from tally round deals four again.
    deal(1, 4, 1);
    expect_probe(1, 0, 0, 0, 0);
    adv(1);
    expect_probe(1, 1, 0, 0, 0);
    tick();
    expect_probe(1, 1, 0, 0, 0);
    adv(1);
    expect_probe(1, 2, 0, 0, 0);
    hand_q.push_back('{1, 1});
    adv(1);
    expect_probe(1, 0, 1, 0, 1);
    deal(1, 4, 6);
    expect_probe(1, 0, 0, 0, 1);

    repeat (3) tick();
    done = 1'b1;
  end

endmodule

// File: doc/round_controller.md
ROUND_CONTROLLER -- requirements
Module: round_controller

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, named clk and rst.
REQ-002 Parameter NUM_ROUNDS, default 5, SHALL set the rounds per hand (0..NUM_ROUNDS-1); the last round is the tally round; legal range is 2 to 16.
REQ-003 Parameter DEAL_FIRST, default 4, SHALL set the cards dealt on entry to round 0; legal range is 1 to 15.
REQ-004 Parameter DEAL_REST, default 1, SHALL set the cards dealt on entry to each of rounds 1..NUM_ROUNDS-2; legal range is 0 to 15.
REQ-005 Parameter HAND_W, default 8, SHALL set the width of the hand counter.
REQ-006 Derived width RW SHALL equal clog2(NUM_ROUNDS), with a minimum of 1.
REQ-007 Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- advance  in  1  one-cycle pulse requesting the next round
- cashout  in  1  level, debounced cashout switch
- deal_ack  in  1  card source accepts a request this cycle
- deal_data  in  4  card value, valid when deal_ack=1
- deal_req  out  1  card request
- card_out  out  4  last dealt card
- card_valid  out  1  one-cycle pulse; card_out is updated
- round  out  RW  current round index
- cashed_out  out  1  high in the CASHOUT state
- hand_done  out  1  one-cycle pulse when a hand completes
- hand_cnt  out  HAND_W  completed hands, modulo 2^HAND_W

Function
REQ-008 The FSM SHALL have the states INIT, DEAL, WAIT and CASHOUT, with all transitions taken on the rising edge of clk.
REQ-009 INIT SHALL unconditionally go to DEAL one cycle later, with round=0 and the deal counter loaded with DEAL_FIRST.
REQ-010 In DEAL:
- deal_req SHALL be 1.
- On each cycle with deal_ack=1, the block SHALL register deal_data into card_out, pulse card_valid in the next cycle, and decrement the deal counter.
REQ-011 When the ack that consumes the final card occurs, the FSM SHALL go to WAIT, and deal_req SHALL be 0 from the next cycle; no further request cycle is issued.
REQ-012 A deal_ack that arrives outside DEAL SHALL be ignored: card_out is unchanged and card_valid is not pulsed.
REQ-013 advance SHALL be ignored while in DEAL; it is dropped, not queued.
REQ-014 In WAIT with round < NUM_ROUNDS-1, advance SHALL increment round.
- If the new round is below NUM_ROUNDS-1 and DEAL_REST > 0, the FSM SHALL go to DEAL with the counter loaded with DEAL_REST.
- Otherwise it SHALL stay in WAIT.
REQ-015 In WAIT with round = NUM_ROUNDS-1 (the tally round):
- cashout=1 SHALL go to CASHOUT.
- Otherwise, advance SHALL set round=0, pulse hand_done, increment hand_cnt, and go to DEAL with DEAL_FIRST.
REQ-016 If cashout=1 and advance=1 occur in the same cycle in the tally round, cashout SHALL win; hand_done is not pulsed.
REQ-017 cashout SHALL have no effect in rounds other than the tally round.
REQ-018 In CASHOUT:
- cashed_out SHALL be 1 and advance SHALL be ignored.
- When cashout=0, the block SHALL pulse hand_done, increment hand_cnt, and go to INIT.
REQ-019 hand_cnt SHALL wrap from 2^HAND_W-1 to 0 without any flag.
REQ-020 All outputs SHALL be registered, and no output SHALL depend combinationally on any input.

Reset
REQ-021 rst=1 SHALL immediately force the following values, regardless of the current state, including mid-deal:
- state=INIT, round=0
- deal_req=0, card_out=0, card_valid=0
- cashed_out=0, hand_done=0, hand_cnt=0
- deal counter=0
REQ-022 After rst is released, the first request cycle SHALL be the second clk edge: INIT, then DEAL.

Verification
REQ-023 Reset release with deal_ack held at 1 and deal_data=3,7,9,2 -> exactly 4 card_valid pulses with card_out 3,7,9,2, then round=0 in WAIT with deal_req=0.
REQ-024 Four advance pulses, each followed by acks -> round steps 1,2,3 with one card dealt in each, then round=4 with no deal.
REQ-025 In round 4, cashout=1 and advance=1 in the same cycle -> cashed_out=1 and hand_done not pulsed; then cashout=0 -> hand_done pulses, hand_cnt=1, round=0, DEAL.
REQ-026 advance pulsed during DEAL with deal_ack=0 -> round unchanged and the pulse is not replayed after the deal completes.
REQ-027 With DEAL_REST=0 and NUM_ROUNDS=3 -> advance moves 0->1 with no deal_req; advance moves 1->2; advance wraps to 0, pulses hand_done, and deals 4 cards.
REQ-028 rst asserted after the second of four acks -> all outputs return to their reset values asynchronously, and the next deal requests 4 fresh cards.
